// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   RESET_PC   : boot vector, recorded as the trace PC out of reset
//   NOP_INSTR  : encoding substituted for instructions that must not execute
//   fe_state_e : fetch-stage occupancy (empty, live SRAM data, buffered data)
package mips_defs;

  localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no live fetch
    LIVE = 2'd1,  // instruction is the SRAM read data of this cycle
    HELD = 2'd2   // decode stalled; instruction comes from the hold buffer
  } fe_state_e;

endpackage

// File: rtl/mips_fetch_stage_buf.sv
// One-entry hold register for the instruction SRAM read data.
//   clk, rst   : clock, asynchronous active-high reset
//   capture_i  : latch rdata_i at the coming edge (first stalled edge)
//   select_i   : present the buffered word instead of the live SRAM data
//   rdata_i    : instruction SRAM read data
//   instr_o    : selected instruction word
module mips_fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic        select_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] instr_o
);

  logic [31:0] buf_q;

  // NOTE: a single 32-bit register, not a memory array, so it takes the
  // async reset like any other flop and comes out of reset as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (capture_i) begin
      // NOTE: sequential state is written only with non-blocking assignments.
      buf_q <= rdata_i;
    end
  end

  assign instr_o = select_i ? buf_q : rdata_i;

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage of the five-stage MIPS pipeline.
// Registers the next PC whenever the stage may advance, issues the aligned
// address to the synchronous instruction SRAM, and offers {PC, instruction}
// to decode under a valid/allowin handshake. A decode stall parks the SRAM
// data in a one-entry buffer so the SRAM can be idled.
//   clk, rst          : clock, asynchronous active-high reset
//   nextpc            : next fetch address from PC calculation
//   flush             : redirect from EX; kills the current IF content
//   de_allowin        : decode accepts an instruction this cycle
//   fe_allowin        : IF accepts nextpc at the coming edge
//   fe_valid, fe_pc   : live fetch flag and its PC
//   fe_to_de_valid    : instruction offered to decode
//   fe_instruction    : instruction word (NOP when misaligned)
//   fe_adel           : misaligned fetch PC, for AdEL in decode
//   inst_sram_*       : synchronous instruction SRAM port
module mips_fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = mips_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] nextpc,
  input  logic        flush,
  input  logic        de_allowin,
  output logic        fe_allowin,
  output logic        fe_valid,
  output logic [31:0] fe_pc,
  output logic        fe_to_de_valid,
  output logic [31:0] fe_instruction,
  output logic        fe_adel,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata
);

  fe_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        capture;
  logic [31:0] buf_instr;

  assign fe_valid       = (state_q != IDLE);
  // A flush always frees the stage so the redirect target is taken at once.
  assign fe_allowin     = !fe_valid || de_allowin || flush;
  // Disabled while stalled so the SRAM output is not overwritten by a re-read.
  assign inst_sram_en   = fe_allowin && !rst;
  assign inst_sram_addr = {nextpc[31:2], 2'b00};
  assign fe_to_de_valid = fe_valid && !flush;
  assign fe_pc          = pc_q;
  assign fe_adel        = fe_valid && (pc_q[1:0] != 2'b00);

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    if (fe_allowin) begin
      state_d = LIVE;
      pc_d    = nextpc;
    end else if (state_q == LIVE) begin
      // First stalled edge: park the data before the SRAM output goes stale.
      state_d = HELD;
      capture = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  mips_fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .capture_i (capture),
    .select_i  (state_q == HELD),
    .rdata_i   (inst_sram_rdata),
    .instr_o   (buf_instr)
  );

  assign fe_instruction = fe_adel ? NOP_INSTR : buf_instr;

endmodule
